csc_group_tracker: RTL and testbench
====================================

# csc_group_tracker

Consumer-side controller for the CSC ping-pong register groups. It decides which group (0 or 1) the convolution datapath executes next, and launches a layer when that group's op_en is set. When the datapath reports the layer done, it clears that group's op_en and toggles the consumer pointer. It drives the read-only consumer and status_0/status_1 fields of the CSC single-register block.

## Interface
- CNT_W, default 32: width of the completed-layer counter. Used only when the counter is compiled in.
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- reg2dp_op_en_0  in  1  level; group 0 programmed and armed by software.
- reg2dp_op_en_1  in  1  level; group 1 programmed and armed by software.
- dp2reg_done  in  1  one-cycle pulse from the datapath; current layer finished.
- consumer  out  1  group currently owned or next to be executed by hardware.
- status_0  out  2  group 0 state: 0 = IDLE, 1 = RUNNING, 2 = PENDING. The value 3 is never driven.
- status_1  out  2  group 1 state, same encoding.
- layer_start  out  1  one-cycle pulse; datapath begins the layer using group layer_group.
- layer_group  out  1  group index of the active layer; valid while busy.
- op_en_clr_0  out  1  one-cycle pulse; clears group 0 op_en in the dual-register block.
- op_en_clr_1  out  1  one-cycle pulse; clears group 1 op_en.
- busy  out  1  high in RUN and DONE.
- layer_cnt  out  CNT_W  completed-layer count. Present only with NVDLA_CSC_LAYER_CNT_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN when op_en of group consumer is 1. layer_group is loaded with consumer. op_en of the non-consumer group is ignored in IDLE; groups execute strictly in alternating order.
- RUN → DONE on dp2reg_done.
- RUN holds while op_en of the active group drops. A software clear does not abort the layer.
- DONE → IDLE unconditionally after one cycle. On this transition, consumer toggles.
- op_en_clr_g is asserted for exactly the single DONE cycle, for g = layer_group.
- layer_start is asserted for exactly the first RUN cycle.
- dp2reg_done in IDLE or DONE is ignored and has no state effect.
- Status per group g, registered each cycle from next-state values:
  - RUNNING (1) if next state is RUN or DONE and g equals the next layer_group.
  - otherwise PENDING (2) if reg2dp_op_en_g is 1.
  - otherwise IDLE (0).
- All outputs reset to 0: consumer=0, status_0=0, status_1=0, layer_start=0, layer_group=0, op_en_clr_0=0, op_en_clr_1=0, busy=0, layer_cnt=0.
- Reset mid-layer returns the block to IDLE with consumer=0. No op_en_clr pulse is issued, and software must re-arm.

## Timing
- op_en of group consumer rises, sampled high at edge T in IDLE → state RUN, layer_start=1, busy=1 and status=RUNNING from T+1.
- dp2reg_done at edge R → DONE and op_en_clr from R+1; consumer toggles and state is IDLE at R+2.
- The dual-register block clears op_en at edge R+2. status then reads IDLE, or PENDING for the other group if it is armed.
- Back-to-back layers: the other group is already armed → next layer_start at R+3. The minimum gap between done and the next start is 3 cycles.
- consumer and status change only on clock edges; they never glitch combinationally.

## Configuration
- NVDLA_CSC_LAYER_CNT_EN defined:
  - the layer_cnt port exists;
  - the counter increments by 1 on every DONE cycle and wraps from 2^CNT_W−1 to 0;
  - it is cleared only by reset.
- NVDLA_CSC_LAYER_CNT_EN undefined:
  - the port and counter are absent;
  - all other behaviour is identical.

## Structure
- Shared package holds:
  - status encodings CSC_GRP_IDLE=2'd0, CSC_GRP_RUNNING=2'd1, CSC_GRP_PENDING=2'd2;
  - FSM state encoding IDLE/RUN/DONE.
- Single flat module. No sub-module is warranted; the status computation stays inline for both groups.

## Test plan
- Reset, then arm group 0 at cycle 5:
  - layer_start at 6, layer_group=0, status_0=1, status_1=0;
  - dp2reg_done at 20 → op_en_clr_0 at 21, consumer=1 at 22.
- Arm both groups before start:
  - status_1=2 while group 0 runs;
  - after group 0 done at R, layer_start at R+3 with layer_group=1, then consumer returns to 0.
- Arm only group 1 with consumer=0 → no layer_start for 50 cycles; status_1=2, busy=0.
- dp2reg_done pulses in IDLE and a double pulse in RUN → only one DONE, one op_en_clr, one toggle; spurious pulses ignored.
- Assert reset during RUN → all outputs 0 on the next sample and FSM IDLE. After release with group 0 armed, a fresh layer_start occurs.
- With NVDLA_CSC_LAYER_CNT_EN, CNT_W=4: complete 17 layers → layer_cnt=1 (wrapped). Without the macro the design elaborates with no layer_cnt port.

Source files
------------

// File: rtl/csc_group_tracker_pkg.sv
// Shared encodings for the CSC ping-pong group tracker: per-group status
// values and the consumer FSM state type.
package csc_group_tracker_pkg;

    localparam logic [1:0] CSC_GRP_IDLE    = 2'd0;
    localparam logic [1:0] CSC_GRP_RUNNING = 2'd1;
    localparam logic [1:0] CSC_GRP_PENDING = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } csc_state_e;

endpackage

// File: rtl/csc_group_tracker.sv
// Consumer-side controller for the CSC ping-pong register groups.
// Optional completed-layer counter: define NVDLA_CSC_LAYER_CNT_EN.
module csc_group_tracker
    import csc_group_tracker_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       reg2dp_op_en_0,
    input  logic       reg2dp_op_en_1,
    input  logic       dp2reg_done,
    output logic       consumer,
    output logic [1:0] status_0,
    output logic [1:0] status_1,
    output logic       layer_start,
    output logic       layer_group,
    output logic       op_en_clr_0,
    output logic       op_en_clr_1,
    output logic       busy
`ifdef NVDLA_CSC_LAYER_CNT_EN
    ,
    output logic [CNT_W-1:0] layer_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("csc_group_tracker: CNT_W must be at least 1");
    end

    csc_state_e state_q;
    csc_state_e next_state;
    logic       consumer_q;
    logic       layer_group_q;
    logic       layer_start_q;
    logic [1:0] status_0_q;
    logic [1:0] status_1_q;

    logic       cur_op_en;
    logic       launch;
    logic       next_group;
    logic       next_active;
    logic [1:0] status_0_next;
    logic [1:0] status_1_next;

    // Only the consumer group may launch; the other group's op_en is ignored
    assign cur_op_en = consumer_q ? reg2dp_op_en_1 : reg2dp_op_en_0;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE: if (cur_op_en)   next_state = ST_RUN;
            ST_RUN:  if (dp2reg_done) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Status is computed from next-state values so it lines up with the FSM
    always_comb begin
        launch      = (state_q == ST_IDLE) && (next_state == ST_RUN);
        next_group  = launch ? consumer_q : layer_group_q;
        next_active = (next_state != ST_IDLE);

        if (next_active && !next_group) begin
            status_0_next = CSC_GRP_RUNNING;
        end else if (reg2dp_op_en_0) begin
            status_0_next = CSC_GRP_PENDING;
        end else begin
            status_0_next = CSC_GRP_IDLE;
        end

        if (next_active && next_group) begin
            status_1_next = CSC_GRP_RUNNING;
        end else if (reg2dp_op_en_1) begin
            status_1_next = CSC_GRP_PENDING;
        end else begin
            status_1_next = CSC_GRP_IDLE;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            consumer_q    <= 1'b0;
            layer_group_q <= 1'b0;
            layer_start_q <= 1'b0;
            status_0_q    <= CSC_GRP_IDLE;
            status_1_q    <= CSC_GRP_IDLE;
        end else begin
            consumer_q    <= consumer_q ^ (state_q == ST_DONE);
            layer_group_q <= next_group;
            layer_start_q <= launch;
            status_0_q    <= status_0_next;
            status_1_q    <= status_1_next;
        end
    end

    assign consumer    = consumer_q;
    assign status_0    = status_0_q;
    assign status_1    = status_1_q;
    assign layer_start = layer_start_q;
    assign layer_group = layer_group_q;
    assign busy        = (state_q != ST_IDLE);
    assign op_en_clr_0 = (state_q == ST_DONE) && !layer_group_q;
    assign op_en_clr_1 = (state_q == ST_DONE) &&  layer_group_q;

`ifdef NVDLA_CSC_LAYER_CNT_EN
    logic [CNT_W-1:0] layer_cnt_q;

    // Wraps naturally at 2^CNT_W; only reset clears it
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            layer_cnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            layer_cnt_q <= layer_cnt_q + CNT_W'(1);
        end
    end

    assign layer_cnt = layer_cnt_q;
`endif

endmodule

// File: tb/tb_csc_group_tracker.sv
// Scoreboard bench for csc_group_tracker: stimulus queues expected snapshots
// and events, a negedge monitor pops and compares them.
module tb_csc_group_tracker;

    logic       clk;
    logic       rstn;
    logic       op_en_0;
    logic       op_en_1;
    logic       done;
    logic       consumer;
    logic [1:0] status_0;
    logic [1:0] status_1;
    logic       layer_start;
    logic       layer_group;
    logic       op_en_clr_0;
    logic       op_en_clr_1;
    logic       busy;
`ifdef NVDLA_CSC_LAYER_CNT_EN
    logic [3:0] layer_cnt;
`endif

    csc_group_tracker #(.CNT_W(4)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .reg2dp_op_en_0  (op_en_0),
        .reg2dp_op_en_1  (op_en_1),
        .dp2reg_done     (done),
        .consumer        (consumer),
        .status_0        (status_0),
        .status_1        (status_1),
        .layer_start     (layer_start),
        .layer_group     (layer_group),
        .op_en_clr_0     (op_en_clr_0),
        .op_en_clr_1     (op_en_clr_1),
        .busy            (busy)
`ifdef NVDLA_CSC_LAYER_CNT_EN
        ,
        .layer_cnt       (layer_cnt)
`endif
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] val;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } ev_t;

    snap_t snap_q[$];
    ev_t   start_q[$];
    ev_t   clr_q[$];
    int    cyc;
    int    n_cmp;
    int    n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [9:0] pk(input logic c, input logic [1:0] s0, input logic [1:0] s1,
                                      input logic b, input logic st, input logic g, input logic [1:0] clr);
        return {c, s0, s1, b, st, g, clr};
    endfunction

    task automatic exp_snap(input int c, input string n, input logic [9:0] v);
        snap_t s;
        s.cyc = c; s.name = n; s.val = v;
        snap_q.push_back(s);
    endtask

    task automatic exp_start(input int c, input logic g);
        ev_t e;
        e.cyc = c; e.val = {1'b0, g};
        start_q.push_back(e);
    endtask

    task automatic exp_clr(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c; e.val = v;
        clr_q.push_back(e);
    endtask

    task automatic go_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: compares queued snapshots and every start/clear pulse the DUT emits
    always @(negedge clk) begin
        snap_t s;
        ev_t   e;
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            if (s.cyc < cyc) check_output({s.name, "_missed"}, 32'(cyc), 32'(s.cyc));
            else check_output(s.name, 32'({consumer, status_0, status_1, busy, layer_start,
                                           layer_group, op_en_clr_1, op_en_clr_0}), 32'(s.val));
        end
        if (layer_start) begin
            if (start_q.size() == 0) check_output("unexpected_start", 32'(1), 32'(0));
            else begin
                e = start_q.pop_front();
                check_output("start_cyc", 32'(cyc), 32'(e.cyc));
                check_output("start_grp", 32'(layer_group), 32'(e.val[0]));
            end
        end
        if (op_en_clr_0 || op_en_clr_1) begin
            if (clr_q.size() == 0) check_output("unexpected_clr", 32'(1), 32'(0));
            else begin
                e = clr_q.pop_front();
                check_output("clr_cyc", 32'(cyc), 32'(e.cyc));
                check_output("clr_val", 32'({op_en_clr_1, op_en_clr_0}), 32'(e.val));
            end
        end
    end

    task automatic run_layer(input logic g);
        int c;
        c = cyc;
        exp_start(c + 1, g);
        exp_clr(c + 4, g ? 2'b10 : 2'b01);
        if (g) op_en_1 = 1'b1; else op_en_0 = 1'b1;
        go_to(c + 3);
        done = 1'b1;
        go_to(c + 4);
        done = 1'b0;
        if (g) op_en_1 = 1'b0; else op_en_0 = 1'b0;
        go_to(c + 5);
    endtask

    task automatic apply_stimulus();
        // Reset and single layer on group 0
        exp_snap(1, "reset", pk(0, 0, 0, 0, 0, 0, 2'b00));
        exp_snap(3, "post_reset", pk(0, 0, 0, 0, 0, 0, 2'b00));
        exp_start(6, 1'b0);
        exp_clr(21, 2'b01);
        exp_snap(6, "a_start", pk(0, 1, 0, 1, 1, 0, 2'b00));
        exp_snap(7, "a_run", pk(0, 1, 0, 1, 0, 0, 2'b00));
        exp_snap(21, "a_done", pk(0, 1, 0, 1, 0, 0, 2'b01));
        exp_snap(22, "a_idle", pk(1, 0, 0, 0, 0, 0, 2'b00));
        exp_snap(27, "idle_done_ignored", pk(1, 0, 0, 0, 0, 0, 2'b00));
        go_to(2);  rstn = 1'b1;
        go_to(5);  op_en_0 = 1'b1;
        go_to(20); done = 1'b1;
        go_to(21); done = 1'b0; op_en_0 = 1'b0;
        go_to(25); done = 1'b1;
        go_to(26); done = 1'b0;

        // Reset in the middle of a group-1 layer, then restart on group 0
        exp_start(31, 1'b1);
        exp_snap(31, "b_start", pk(1, 0, 1, 1, 1, 1, 2'b00));
        exp_snap(36, "b_reset", pk(0, 0, 0, 0, 0, 0, 2'b00));
        exp_snap(38, "b_released", pk(0, 0, 0, 0, 0, 0, 2'b00));
        exp_start(40, 1'b0);
        exp_snap(40, "b_restart", pk(0, 1, 0, 1, 1, 0, 2'b00));
        go_to(30); op_en_1 = 1'b1;
        go_to(35); rstn = 1'b0; op_en_1 = 1'b0;
        go_to(37); rstn = 1'b1;
        go_to(39); op_en_0 = 1'b1;

        // Group 1 armed during group 0 run, double done pulse, back-to-back
        exp_snap(43, "c_pending", pk(0, 1, 2, 1, 0, 0, 2'b00));
        exp_clr(47, 2'b01);
        exp_snap(47, "c_done0", pk(0, 1, 2, 1, 0, 0, 2'b01));
        exp_snap(48, "c_idle", pk(1, 0, 2, 0, 0, 0, 2'b00));
        exp_start(49, 1'b1);
        exp_snap(49, "c_start1", pk(1, 0, 1, 1, 1, 1, 2'b00));
        exp_clr(56, 2'b10);
        exp_snap(56, "c_done1", pk(1, 0, 1, 1, 0, 1, 2'b10));
        exp_snap(57, "c_back0", pk(0, 0, 0, 0, 0, 1, 2'b00));
        go_to(42); op_en_1 = 1'b1;
        go_to(46); done = 1'b1;
        go_to(47); op_en_0 = 1'b0;
        go_to(48); done = 1'b0;
        go_to(55); done = 1'b1;
        go_to(56); done = 1'b0; op_en_1 = 1'b0;

        // Only the non-consumer group armed: nothing may start
        exp_snap(61, "d_wait", pk(0, 0, 2, 0, 0, 1, 2'b00));
        exp_snap(80, "d_wait_mid", pk(0, 0, 2, 0, 0, 1, 2'b00));
        exp_snap(110, "d_wait_end", pk(0, 0, 2, 0, 0, 1, 2'b00));
        exp_snap(112, "d_dropped", pk(0, 0, 0, 0, 0, 1, 2'b00));
        go_to(60);  op_en_1 = 1'b1;
        go_to(111); op_en_1 = 1'b0;
        go_to(113);

`ifdef NVDLA_CSC_LAYER_CNT_EN
        check_output("layer_cnt_after_reset", 32'(layer_cnt), 32'(2));
        for (int i = 0; i < 15; i++) run_layer(1'(i % 2));
        check_output("layer_cnt_wrapped", 32'(layer_cnt), 32'(1));
`else
        run_layer(1'b0);
        run_layer(1'b1);
`endif
        go_to(cyc + 5);
    endtask

    initial begin
        cyc     = 0;
        n_cmp   = 0;
        n_bad   = 0;
        rstn    = 1'b0;
        op_en_0 = 1'b0;
        op_en_1 = 1'b0;
        done    = 1'b0;
        apply_stimulus();
        check_output("snap_q_left", 32'(snap_q.size()), 32'(0));
        check_output("start_q_left", 32'(start_q.size()), 32'(0));
        check_output("clr_q_left", 32'(clr_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
